// File: rtl/mem_wb_pkg.sv
// mem_wb_pkg: load funct3 encodings, MEM->WB FSM states and alignment helper.
package mem_wb_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [0:0] {IDLE, WAIT_DM} mwb_state_e;

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
        return ((funct3 == F3_LH || funct3 == F3_LHU) && off[0]) || (funct3 == F3_LW && off != 2'b00);
    endfunction

endpackage

// File: rtl/load_extend.sv
// load_extend: picks the addressed byte/half/word out of a DM word and sign/zero-extends it.
module load_extend
    import mem_wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] dm_rdata,
    input  logic [2:0]      funct3,
    input  logic [1:0]      byte_off,
    output logic [XLEN-1:0] data,
    output logic            illegal
);

    logic [7:0]  b;
    logic [15:0] h;
    logic        known;

    always_comb begin
        b       = dm_rdata[{byte_off, 3'b000} +: 8];
        h       = byte_off[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        known   = funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
        illegal = !known || is_misaligned(funct3, byte_off);
        data    = funct3 == F3_LB  ? {{(XLEN-8){b[7]}}, b} :
                  funct3 == F3_LBU ? {{(XLEN-8){1'b0}}, b} :
                  funct3 == F3_LH  ? {{(XLEN-16){h[15]}}, h} :
                  funct3 == F3_LHU ? {{(XLEN-16){1'b0}}, h} : dm_rdata;
    end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM->WB register stage that waits on a variable-latency DM response,
// extends load data and emits one registered writeback beat (or a load fault pulse).
module mem_wb_stage
    import mem_wb_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int RA_W       = 5,
    parameter int DM_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic            mem_flush,
    input  logic            mem_mem_to_reg,
    input  logic            mem_reg_write,
    input  logic [XLEN-1:0] mem_rd_data,
    input  logic [RA_W-1:0] mem_rd_addr,
    input  logic [2:0]      mem_funct3,
    input  logic [1:0]      mem_byte_off,
    input  logic            dm_rvalid,
    input  logic [XLEN-1:0] dm_rdata,
    output logic            wb_valid,
    output logic            wb_reg_write,
    output logic [RA_W-1:0] wb_rd_addr,
    output logic [XLEN-1:0] wb_wdata,
    output logic            wb_load_fault
);

    localparam int CNT_W = $clog2(DM_TIMEOUT + 1);

    if (XLEN != 32) begin : g_xlen_check
        $error("mem_wb_stage supports XLEN == 32 only");
    end
    if (DM_TIMEOUT < 1) begin : g_timeout_check
        $error("mem_wb_stage needs DM_TIMEOUT >= 1");
    end

    mwb_state_e       state, state_n;
    logic [CNT_W-1:0] cnt;
    logic [RA_W-1:0]  pend_rd;
    logic [2:0]       pend_f3;
    logic [1:0]       pend_off;
    logic             pend_rw;
    logic [2:0]       ext_f3;
    logic [1:0]       ext_off;
    logic [XLEN-1:0]  ext_data;
    logic             ext_illegal;
    logic             accept, is_load, timeout, beat, fault, rw, we;
    logic [RA_W-1:0]  rd;
    logic [XLEN-1:0]  data;

    assign mem_ready = state == IDLE;

    load_extend #(.XLEN(XLEN)) u_ext (
        .dm_rdata (dm_rdata),
        .funct3   (ext_f3),
        .byte_off (ext_off),
        .data     (ext_data),
        .illegal  (ext_illegal)
    );

    // Live MEM fields steer the extender in IDLE, the latched load fields in WAIT_DM.
    always_comb begin
        ext_f3  = mem_ready ? mem_funct3 : pend_f3;
        ext_off = mem_ready ? mem_byte_off : pend_off;
        accept  = mem_valid & mem_ready & ~mem_flush;
        is_load = accept & mem_mem_to_reg;
        timeout = !mem_ready && cnt == CNT_W'(DM_TIMEOUT - 1);
        beat    = mem_ready ? accept & (~mem_mem_to_reg | ext_illegal | dm_rvalid)
                            : ~mem_flush & (dm_rvalid | timeout);
        fault   = mem_ready ? is_load & ext_illegal : ~mem_flush & ~dm_rvalid & timeout;
        rd      = mem_ready ? mem_rd_addr : pend_rd;
        rw      = mem_ready ? mem_reg_write : pend_rw;
        data    = fault ? '0 : (mem_ready && !mem_mem_to_reg) ? mem_rd_data : ext_data;
        we      = rw & ~fault & (rd != '0);
        state_n = mem_ready ? ((is_load & ~ext_illegal & ~dm_rvalid) ? WAIT_DM : IDLE)
                            : ((mem_flush | dm_rvalid | timeout) ? IDLE : WAIT_DM);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            pend_rd       <= '0;
            pend_f3       <= '0;
            pend_off      <= '0;
            pend_rw       <= 1'b0;
            wb_valid      <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_rd_addr    <= '0;
            wb_wdata      <= '0;
            wb_load_fault <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= (!mem_ready && state_n == WAIT_DM) ? cnt + CNT_W'(1) : '0;
            wb_valid      <= beat;
            wb_reg_write  <= beat & we;
            wb_load_fault <= fault;
            if (accept) begin
                pend_rd  <= mem_rd_addr;
                pend_f3  <= mem_funct3;
                pend_off <= mem_byte_off;
                pend_rw  <= mem_reg_write;
            end
            if (beat) begin
                wb_rd_addr <= rd;
                wb_wdata   <= data;
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: scenario tasks drive MEM/DM stimulus and queue expected beats;
// a negedge monitor pops and compares every writeback beat.
module tb_mem_wb_stage;

    localparam int DM_TIMEOUT = 15;

    typedef struct {
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] d;
        logic        flt;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, mem_ready, mem_flush, mem_mem_to_reg, mem_reg_write;
    logic [31:0] mem_rd_data;
    logic [4:0]  mem_rd_addr;
    logic [2:0]  mem_funct3;
    logic [1:0]  mem_byte_off;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic        wb_valid, wb_reg_write, wb_load_fault;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_wdata;

    int    tests = 0;
    int    fails = 0;
    beat_t sb[$];
    beat_t e;

    mem_wb_stage #(.XLEN(32), .RA_W(5), .DM_TIMEOUT(DM_TIMEOUT)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_flush      (mem_flush),
        .mem_mem_to_reg (mem_mem_to_reg),
        .mem_reg_write  (mem_reg_write),
        .mem_rd_data    (mem_rd_data),
        .mem_rd_addr    (mem_rd_addr),
        .mem_funct3     (mem_funct3),
        .mem_byte_off   (mem_byte_off),
        .dm_rvalid      (dm_rvalid),
        .dm_rdata       (dm_rdata),
        .wb_valid       (wb_valid),
        .wb_reg_write   (wb_reg_write),
        .wb_rd_addr     (wb_rd_addr),
        .wb_wdata       (wb_wdata),
        .wb_load_fault  (wb_load_fault)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (wb_load_fault && !wb_valid) begin
                tests++; fails++;
                $display("FAIL fault_without_valid: wb_load_fault=1 wb_valid=0, required wb_valid=1");
            end
            if (wb_valid) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_beat: got rw=%0b rd=%0d d=%h flt=%0b, required no beat",
                             wb_reg_write, wb_rd_addr, wb_wdata, wb_load_fault);
                end else begin
                    e = sb.pop_front();
                    if ({wb_reg_write, wb_rd_addr, wb_wdata, wb_load_fault} !== {e.rw, e.rd, e.d, e.flt}) begin
                        fails++;
                        $display("FAIL beat: got rw=%0b rd=%0d d=%h flt=%0b, required rw=%0b rd=%0d d=%h flt=%0b",
                                 wb_reg_write, wb_rd_addr, wb_wdata, wb_load_fault, e.rw, e.rd, e.d, e.flt);
                    end
                end
            end
        end
    end

    task automatic idle_inputs();
        mem_valid = 0; mem_flush = 0; mem_mem_to_reg = 0; mem_reg_write = 0;
        mem_rd_data = '0; mem_rd_addr = '0; mem_funct3 = '0; mem_byte_off = '0;
        dm_rvalid = 0; dm_rdata = '0;
    endtask

    task automatic send(input logic ld, input logic rw, input logic [4:0] rd, input logic [31:0] d,
                        input logic [2:0] f3, input logic [1:0] off, input logic rv, input logic [31:0] rdata);
        mem_valid = 1; mem_mem_to_reg = ld; mem_reg_write = rw; mem_rd_addr = rd; mem_rd_data = d;
        mem_funct3 = f3; mem_byte_off = off; dm_rvalid = rv; dm_rdata = rdata;
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic push(input logic rw, input logic [4:0] rd, input logic [31:0] d, input logic flt);
        sb.push_back('{rw: rw, rd: rd, d: d, flt: flt});
    endtask

    task automatic test_reset();
        rst = 1; idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({wb_valid, wb_reg_write, wb_rd_addr, wb_wdata, wb_load_fault, mem_ready} !== {1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL reset: got v=%0b we=%0b rd=%0d d=%h f=%0b rdy=%0b, required all 0 and rdy=1",
                     wb_valid, wb_reg_write, wb_rd_addr, wb_wdata, wb_load_fault, mem_ready);
        end
        rst = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_alu();
        push(1, 5'd5, 32'h1234_5678, 0);
        send(0, 1, 5'd5, 32'h1234_5678, 3'b011, 2'd3, 0, '0);
        @(negedge clk);
        tests++;
        if (wb_valid !== 1'b1) begin
            fails++; $display("FAIL alu_latency: wb_valid=%0b, required 1", wb_valid);
        end
        @(posedge clk); #1;
        @(negedge clk);
        tests++;
        if ({wb_valid, wb_reg_write, wb_wdata} !== {1'b0, 1'b0, 32'h1234_5678}) begin
            fails++;
            $display("FAIL alu_hold: got v=%0b we=%0b d=%h, required v=0 we=0 d=12345678", wb_valid, wb_reg_write, wb_wdata);
        end
        push(0, 5'd7, 32'hCAFE_0001, 0);
        send(0, 0, 5'd7, 32'hCAFE_0001, 3'b000, 2'd0, 0, '0);
        @(posedge clk); #1;
    endtask

    task automatic test_load_same_cycle();
        push(1, 5'd3, 32'hFFFF_FF80, 0);
        send(1, 1, 5'd3, '0, 3'b000, 2'd3, 1, 32'h80FF_FF7F);
        push(1, 5'd4, 32'h0000_0080, 0);
        send(1, 1, 5'd4, '0, 3'b100, 2'd3, 1, 32'h80FF_FF7F);
        push(1, 5'd6, 32'h0000_007F, 0);
        send(1, 1, 5'd6, '0, 3'b000, 2'd0, 1, 32'h80FF_FF7F);
        push(1, 5'd8, 32'h0000_8001, 0);
        send(1, 1, 5'd8, '0, 3'b101, 2'd2, 1, 32'h8001_0000);
        push(1, 5'd9, 32'hFFFF_FFFF, 0);
        send(1, 1, 5'd9, '0, 3'b001, 2'd0, 1, 32'h8001_FFFF);
        push(1, 5'd10, 32'hDEAD_BEEF, 0);
        send(1, 1, 5'd10, '0, 3'b010, 2'd0, 1, 32'hDEAD_BEEF);
        @(posedge clk); #1;
    endtask

    task automatic test_wait_dm();
        push(1, 5'd11, 32'hFFFF_8001, 0);
        send(1, 1, 5'd11, '0, 3'b001, 2'd2, 0, '0);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin dm_rvalid = 1; dm_rdata = 32'h8001_0000; end
            @(negedge clk);
            tests++;
            if (mem_ready !== 1'b0) begin
                fails++; $display("FAIL wait_ready cycle %0d: mem_ready=%0b, required 0", i, mem_ready);
            end
            @(posedge clk); #1;
        end
        idle_inputs();
        @(negedge clk);
        tests++;
        if ({mem_ready, wb_valid} !== 2'b11) begin
            fails++; $display("FAIL wait_done: rdy=%0b v=%0b, required 1 1", mem_ready, wb_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_faults();
        push(0, 5'd12, 32'h0, 1);
        send(1, 1, 5'd12, '0, 3'b010, 2'd1, 1, 32'hFFFF_FFFF);
        @(negedge clk);
        tests++;
        if ({mem_ready, wb_load_fault, wb_reg_write} !== 3'b110) begin
            fails++; $display("FAIL lw_misaligned: rdy=%0b f=%0b we=%0b, required 1 1 0", mem_ready, wb_load_fault, wb_reg_write);
        end
        push(0, 5'd13, 32'h0, 1);
        send(1, 1, 5'd13, '0, 3'b011, 2'd0, 0, '0);
        push(0, 5'd14, 32'h0, 1);
        send(1, 1, 5'd14, '0, 3'b101, 2'd1, 0, '0);
        @(negedge clk);
        tests++;
        if (mem_ready !== 1'b1) begin
            fails++; $display("FAIL fault_no_wait: mem_ready=%0b, required 1", mem_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_timeout();
        int cyc;
        cyc = -1;
        push(0, 5'd15, 32'h0, 1);
        send(1, 1, 5'd15, '0, 3'b010, 2'd0, 0, '0);
        for (int k = 0; k < 3 * DM_TIMEOUT && cyc < 0; k++) begin
            @(negedge clk);
            if (wb_load_fault) begin
                cyc = k;
                tests++;
                if (mem_ready !== 1'b1) begin
                    fails++; $display("FAIL timeout_ready: mem_ready=%0b, required 1", mem_ready);
                end
            end
            @(posedge clk); #1;
        end
        tests++;
        if (cyc != DM_TIMEOUT) begin
            fails++; $display("FAIL timeout_cycles: fault after %0d cycles (-1 = never), required %0d", cyc, DM_TIMEOUT);
        end
    endtask

    task automatic test_flush();
        send(1, 1, 5'd16, '0, 3'b010, 2'd0, 0, '0);
        repeat (2) @(posedge clk); #1;
        mem_flush = 1; dm_rvalid = 1; dm_rdata = 32'h1111_2222;
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        tests++;
        if ({wb_valid, wb_load_fault, mem_ready} !== 3'b001) begin
            fails++; $display("FAIL flush_wait: v=%0b f=%0b rdy=%0b, required 0 0 1", wb_valid, wb_load_fault, mem_ready);
        end
        mem_flush = 1;
        send(0, 1, 5'd17, 32'h5555_5555, 3'b000, 2'd0, 0, '0);
        @(negedge clk);
        tests++;
        if (wb_valid !== 1'b0) begin
            fails++; $display("FAIL flush_idle: wb_valid=%0b, required 0", wb_valid);
        end
        push(0, 5'd0, 32'h0000_00AB, 0);
        send(1, 1, 5'd0, '0, 3'b100, 2'd0, 1, 32'h0000_00AB);
        @(negedge clk);
        tests++;
        if ({wb_valid, wb_reg_write} !== 2'b10) begin
            fails++; $display("FAIL rd_x0: v=%0b we=%0b, required 1 0", wb_valid, wb_reg_write);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 4; i++) begin
            push(1, 5'(i + 20), 32'hA000_0000 + 32'(i), 0);
            send(0, 1, 5'(i + 20), 32'hA000_0000 + 32'(i), 3'b000, 2'd0, 0, '0);
        end
        dm_rvalid = 1; dm_rdata = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk); #1;
        idle_inputs();
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_wait();
        send(1, 1, 5'd18, '0, 3'b010, 2'd0, 0, '0);
        @(posedge clk); #2;
        rst = 1;
        #1;
        tests++;
        if ({mem_ready, wb_valid} !== 2'b10) begin
            fails++; $display("FAIL async_reset: rdy=%0b v=%0b, required 1 0", mem_ready, wb_valid);
        end
        @(posedge clk); #1;
        rst = 0;
        dm_rvalid = 1; dm_rdata = 32'h7777_7777;
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        tests++;
        if ({wb_valid, wb_wdata} !== {1'b0, 32'h0}) begin
            fails++; $display("FAIL stale_rvalid: v=%0b d=%h, required 0 00000000", wb_valid, wb_wdata);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_same_cycle();
        test_wait_dm();
        test_faults();
        test_timeout();
        test_flush();
        test_back_to_back();
        test_reset_mid_wait();
        repeat (2) @(posedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++; $display("FAIL missing_beats: %0d expected beats never seen, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
